instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage that feeds the 8-bit non-pipelined core's decode/control logic.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Latches each returned 8-bit instruction and presents it with pre-split fields (opcode, rs, rt/rd, 3-bit immediate) until the core acknowledges execution.
- Applies branch/jump redirects, detects the halt instruction, and flags memory timeouts.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_INSTR, 8'hFF, encoding that stops fetching once acknowledged.
- MEM_TIMEOUT, 15, maximum WAIT cycles before fault (1..255).

Ports:
- clk1  in  1  system clock, rising edge.
- reset1  in  1  asynchronous, active-low reset.
- imem_req  out  1  one-cycle fetch request strobe.
- imem_addr  out  8  fetch address, equals pc_output whenever imem_req=1.
- imem_rdata  in  8  instruction returned by memory.
- imem_valid  in  1  imem_rdata valid this cycle.
- instr_valid  out  1  instruction held on instr/field outputs.
- instr  out  8  latched instruction.
- opcode  out  3  instr[7:5].
- rs_reg  out  1  instr[4].
- rt_rd_reg  out  1  instr[3].
- imm  out  3  instr[2:0].
- pc_output  out  8  PC of the current/pending instruction.
- instr_ack  in  1  core finished the current instruction.
- redirect_en  in  1  take redirect_target; sampled only with instr_ack.
- redirect_target  in  8  next PC when redirect_en=1.
- halted  out  1  HALT state reached.
- fault  out  1  memory timeout; sticky.
- retired_count  out  8  acknowledged instructions, saturating at 8'hFF.

Behaviour:
- Reset (reset1=0, takes effect immediately regardless of clock):
  - State=IDLE, pc=RESET_PC, instr=8'h00.
  - All outputs 0 except pc_output=imem_addr=RESET_PC.
  - Timeout counter and retired_count cleared.
  - Reset mid-fetch abandons the request; a late imem_valid is ignored because the FSM is not in WAIT.
- FSM states: IDLE, REQ, WAIT, ISSUE, HALT, FAULT. One-hot or binary encoding is acceptable.
- IDLE: on the first rising edge with reset1=1, go to REQ.
- REQ:
  - imem_req=1 for exactly this cycle; imem_addr=pc.
  - Next state WAIT; timeout counter cleared.
- WAIT:
  - imem_req=0; counter increments each cycle.
  - imem_valid=1: latch imem_rdata into instr, go to ISSUE.
  - Counter reaches MEM_TIMEOUT without valid: go to FAULT.
  - imem_valid is sampled only in WAIT, so earliest data is the cycle after REQ.
- Minimum latency: reset release edge → IDLE→REQ (edge 1) → WAIT (edge 2) → data latched at edge 3 → instr_valid high after edge 3.
- ISSUE:
  - instr_valid=1; instr, fields and pc_output are stable until instr_ack.
  - On instr_ack:
    - retired_count increments (saturates at 8'hFF).
    - If instr==HALT_INSTR: go to HALT; redirect is ignored and pc is unchanged.
    - Otherwise pc <= redirect_en ? redirect_target : pc+1, with modulo-256 wrap (8'hFF→8'h00); go to REQ.
  - instr_valid drops the cycle after ack.
- HALT: halted=1, instr_valid=0, no requests; exit only via reset.
- FAULT: fault=1, instr_valid=0, no requests; exit only via reset.
- instr_ack or redirect_en outside ISSUE: ignored.
- imem_valid outside WAIT: ignored.
- Issue-to-next-issue throughput: minimum 3 cycles (REQ, WAIT, ISSUE).

Decomposition:
- Shared package (processor-wide):
  - FSM state encoding.
  - Field bit positions (OPC_MSB=7, OPC_LSB=5, RS_BIT=4, RTRD_BIT=3, IMM_MSB=2).
  - HALT_INSTR default.
  - Instruction width constant 8.
- One natural sub-module: fetch_timeout_counter, with clear, enable, MEM_TIMEOUT compare and expired flag.
- PC update and field slicing stay inline.

Test Plan:
- Reset release with RESET_PC=8'h00 and memory returning 8'h4B one cycle after req → imem_req high at cycle 1 with addr 8'h00; instr_valid at cycle 3 with opcode=3'b010, rs_reg=0, rt_rd_reg=1, imm=3'b011.
- Ack 3 sequential instructions with no redirect → fetch addresses 8'h00, 8'h01, 8'h02; retired_count=3.
- Ack with redirect_en=1 and redirect_target=8'h20 → next imem_addr=8'h20. Separately, pc=8'hFF acked without redirect → next imem_addr=8'h00.
- Memory returns 8'hFF, then ack → halted=1 next cycle, imem_req stays 0 for 20 cycles, retired_count increments once.
- imem_valid withheld for 15 WAIT cycles → fault=1 and stays high; a later imem_valid pulse causes no instr_valid.
- reset1 pulsed low during WAIT, with memory responding 2 cycles later → outputs clear immediately; the stale response is ignored; a fresh fetch from RESET_PC follows the release.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Processor-wide definitions shared by the fetch stage.
//   - fetch FSM state encoding
//   - instruction width and field bit positions of the 8-bit ISA
//   - default halt encoding
package instr_fetch_unit_pkg;

  localparam int INSTR_W  = 8;

  // Field layout: [7:5] opcode, [4] rs, [3] rt/rd, [2:0] immediate
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 5;
  localparam int RS_BIT   = 4;
  localparam int RTRD_BIT = 3;
  localparam int IMM_MSB  = 2;
  localparam int IMM_LSB  = 0;

  localparam logic [INSTR_W-1:0] HALT_INSTR_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_HALT,
    ST_FAULT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_timeout_counter.sv
// Memory-wait timeout counter for the fetch stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (asserted while the request is issued)
//   enable     : count this cycle (asserted while waiting for memory)
//   expired    : this enabled cycle is the MEM_TIMEOUT-th wait cycle
module fetch_timeout_counter #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of wait cycles already completed, so the
  // current cycle is the last permitted one when count == MEM_TIMEOUT-1.
  assign expired = enable && (count >= 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the 8-bit non-pipelined core.
// Owns the PC, issues single-cycle requests to a variable-latency
// instruction memory, holds the returned instruction (with pre-split
// fields) until the core acknowledges it, then advances or redirects.
// Ports:
//   clk1, reset1            : clock, asynchronous active-low reset
//   imem_req/imem_addr      : fetch request strobe and address
//   imem_rdata/imem_valid   : memory response
//   instr_valid, instr      : held instruction and its presence
//   opcode/rs_reg/rt_rd_reg/imm : instruction fields
//   pc_output               : PC of the current/pending instruction
//   instr_ack               : core finished the current instruction
//   redirect_en/_target     : branch/jump redirect, taken with instr_ack
//   halted, fault           : terminal states (halt instruction, timeout)
//   retired_count           : saturating count of acknowledged instructions
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_INSTR  = HALT_INSTR_DEFAULT,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic       clk1,
  input  logic       reset1,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  input  logic       imem_valid,
  output logic       instr_valid,
  output logic [7:0] instr,
  output logic [2:0] opcode,
  output logic       rs_reg,
  output logic       rt_rd_reg,
  output logic [2:0] imm,
  output logic [7:0] pc_output,
  input  logic       instr_ack,
  input  logic       redirect_en,
  input  logic [7:0] redirect_target,
  output logic       halted,
  output logic       fault,
  output logic [7:0] retired_count
);

  fetch_state_t       state_q, state_d;
  logic [7:0]         pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [7:0]         retired_q;
  logic               timeout_expired;
  logic               ack_taken;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  fetch_timeout_counter #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timeout (
    .clk     (clk1),
    .rst_n   (reset1),
    .clear   (state_q == ST_REQ),
    .enable  (state_q == ST_WAIT),
    .expired (timeout_expired)
  );

  assign ack_taken = (state_q == ST_ISSUE) && instr_ack;

  always_ff @(posedge clk1 or negedge reset1) begin
    if (!reset1) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_REQ;
      ST_REQ:   state_d = ST_WAIT;
      // A response arriving in the last permitted cycle still wins.
      ST_WAIT: begin
        if (imem_valid)           state_d = ST_ISSUE;
        else if (timeout_expired) state_d = ST_FAULT;
      end
      ST_ISSUE: begin
        if (instr_ack) state_d = (instr_q == HALT_INSTR) ? ST_HALT : ST_REQ;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // PC, instruction latch and retire counter
  always_ff @(posedge clk1 or negedge reset1) begin
    if (!reset1) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= 8'd0;
    end else begin
      if ((state_q == ST_WAIT) && imem_valid) begin
        instr_q <= imem_rdata;
      end
      if (ack_taken) begin
        retired_q <= sat_inc8(retired_q);
        // A halt keeps its own PC; 8-bit add wraps FF -> 00 naturally.
        if (instr_q != HALT_INSTR) begin
          pc_q <= redirect_en ? redirect_target : pc_q + 8'd1;
        end
      end
    end
  end

  assign imem_req      = (state_q == ST_REQ);
  assign imem_addr     = pc_q;
  assign pc_output     = pc_q;
  assign instr_valid   = (state_q == ST_ISSUE);
  assign halted        = (state_q == ST_HALT);
  assign fault         = (state_q == ST_FAULT);
  assign retired_count = retired_q;

  assign instr     = instr_q;
  assign opcode    = instr_q[OPC_MSB:OPC_LSB];
  assign rs_reg    = instr_q[RS_BIT];
  assign rt_rd_reg = instr_q[RTRD_BIT];
  assign imm       = instr_q[IMM_MSB:IMM_LSB];

endmodule
